cache_control: RTL

CACHE_CONTROL -- requirements
Module: cache_control

---
 rtl/cache_control.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/cache_control.sv
// rtl/cache_control.sv - write-back, write-allocate direct-mapped cache controller FSM with hit/miss/writeback statistics
module cache_control #(
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_resp,
    input  logic                  hit,
    input  logic                  dirty,
    input  logic                  pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic                  pmem_addr_sel,
    output logic                  load_data,
    output logic                  load_tag,
    output logic                  load_valid,
    output logic                  load_dirty,
    output logic                  dirty_in,
    output logic                  datain_sel,
    input  logic                  stat_clr,
    output logic [STAT_WIDTH-1:0] hit_count,
    output logic [STAT_WIDTH-1:0] miss_count,
    output logic [STAT_WIDTH-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0] STAT_ONE = {{(STAT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t next_state;
    logic   retry;

    logic   req;
    logic   is_write;

    // Unqualified decode outputs; the ports below mask them with rst_n so a
    // combinational hit path cannot leak a strobe while reset is held.
    logic   mem_resp_c;
    logic   pmem_read_c;
    logic   pmem_write_c;
    logic   pmem_addr_sel_c;
    logic   load_data_c;
    logic   load_tag_c;
    logic   load_valid_c;
    logic   load_dirty_c;
    logic   dirty_in_c;
    logic   datain_sel_c;

    logic   hit_event;
    logic   miss_event;
    logic   wb_event;
    logic   fill_done;

    // A simultaneous read and write is handled as a write.
    assign req      = mem_read | mem_write;
    assign is_write = mem_write;

    // State register; reset forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and output decode for the three controller states.
    always_comb begin
        next_state      = state;
        mem_resp_c      = 1'b0;
        pmem_read_c     = 1'b0;
        pmem_write_c    = 1'b0;
        pmem_addr_sel_c = 1'b0;
        load_data_c     = 1'b0;
        load_tag_c      = 1'b0;
        load_valid_c    = 1'b0;
        load_dirty_c    = 1'b0;
        dirty_in_c      = 1'b0;
        datain_sel_c    = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp_c = 1'b1;
                        if (is_write) begin
                            load_data_c  = 1'b1;
                            load_dirty_c = 1'b1;
                            dirty_in_c   = 1'b1;
                            datain_sel_c = 1'b0;
                        end
                    end else if (dirty) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write_c    = 1'b1;
                pmem_addr_sel_c = 1'b1;
                if (pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read_c     = 1'b1;
                pmem_addr_sel_c = 1'b0;
                if (pmem_resp) begin
                    load_data_c  = 1'b1;
                    load_tag_c   = 1'b1;
                    load_valid_c = 1'b1;
                    load_dirty_c = 1'b1;
                    dirty_in_c   = 1'b0;
                    datain_sel_c = 1'b1;
                    next_state   = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign mem_resp      = rst_n & mem_resp_c;
    assign pmem_read     = rst_n & pmem_read_c;
    assign pmem_write    = rst_n & pmem_write_c;
    assign pmem_addr_sel = rst_n & pmem_addr_sel_c;
    assign load_data     = rst_n & load_data_c;
    assign load_tag      = rst_n & load_tag_c;
    assign load_valid    = rst_n & load_valid_c;
    assign load_dirty    = rst_n & load_dirty_c;
    assign dirty_in      = rst_n & dirty_in_c;
    assign datain_sel    = rst_n & datain_sel_c;

    // The completion that follows a fill is the tail of a miss, not a hit.
    assign hit_event  = mem_resp_c & ~retry;
    assign miss_event = (state == IDLE) & req & ~hit;
    assign wb_event   = (state == WRITEBACK) & pmem_resp;
    assign fill_done  = (state == ALLOCATE) & pmem_resp;

    // Retry flag marks the IDLE re-evaluation right after a line fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry <= 1'b0;
        end else if (fill_done) begin
            retry <= 1'b1;
        end else if (mem_resp_c || ((state == IDLE) && !req)) begin
            retry <= 1'b0;
        end
    end

    // Saturating statistics counters; clear wins over any increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else if (stat_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if (hit_event && (hit_count != STAT_MAX)) begin
                hit_count <= hit_count + STAT_ONE;
            end
            if (miss_event && (miss_count != STAT_MAX)) begin
                miss_count <= miss_count + STAT_ONE;
            end
            if (wb_event && (wb_count != STAT_MAX)) begin
                wb_count <= wb_count + STAT_ONE;
            end
        end
    end

endmodule
